uart_msg_sender: RTL and testbench

Buffered UART transmit stage that sits downstream of the CPU: it accepts a whole message (packed bytes plus length) on a single-cycle strobe, queues the bytes in an internal FIFO and serialises them as 8N1 frames on `uart_tx`. It replaces direct byte-at-a-time UART driving, so the CPU can post a message and continue without waiting for bit timing.

---
 rtl/uart_msg_sender_pkg.sv | 25 ++
 rtl/uart_byte_tx.sv | 83 ++++++++
 rtl/uart_msg_sender.sv | 131 +++++++++++++
 tb/tb_uart_msg_sender.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_sender_pkg.sv
// Shared definitions for the buffered UART message sender: state encodings and defaults.
package uart_msg_sender_pkg;

    localparam int unsigned DEFAULT_DELAY_FRAMES = 234;
    localparam int unsigned DEFAULT_MSG_BYTES    = 12;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;
    localparam int unsigned BITS_PER_FRAME       = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } ld_state_e;

    function automatic int unsigned frame_cycles(input int unsigned delay_frames);
        return BITS_PER_FRAME * delay_frames;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; accepts a new byte whenever ready is high, allowing back-to-back frames.
module uart_byte_tx
    import uart_msg_sender_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       uart_tx,
    output logic       ready
);

    localparam int unsigned CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);

    tx_state_e        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             cnt_done;

    assign cnt_done = (bit_cnt == CNT_LAST);
    // Ready on the last STOP cycle too, so the next START follows with no idle gap.
    assign ready    = (state == TX_IDLE) || ((state == TX_STOP) && cnt_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= TX_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            if (state != TX_IDLE) begin
                bit_cnt <= cnt_done ? '0 : bit_cnt + 1'b1;
            end
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        shift   <= data;
                        uart_tx <= 1'b0;
                        bit_cnt <= '0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt_done) begin
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (cnt_done) begin
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (cnt_done) begin
                        if (start) begin
                            shift   <= data;
                            uart_tx <= 1'b0;
                            state   <= TX_START;
                        end else begin
                            state   <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_msg_sender.sv
// Buffered UART transmitter: loads a whole message into a byte FIFO and streams it as 8N1 frames.
module uart_msg_sender
    import uart_msg_sender_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int unsigned MSG_BYTES    = DEFAULT_MSG_BYTES,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    localparam int unsigned MSG_W       = MSG_BYTES * 8,
    localparam int unsigned LEN_W       = $clog2(MSG_BYTES + 1),
    localparam int unsigned COUNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MSG_W-1:0]   msgData,
    input  logic [LEN_W-1:0]   msgLen,
    input  logic               msgWrite,
    output logic               busy,
    output logic               overflow,
    output logic [COUNT_W-1:0] fifoCount,
    output logic               txActive,
    output logic               uart_tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    ld_state_e          ld_state;
    logic [MSG_W-1:0]   msg_q;
    logic [LEN_W-1:0]   rem_q;
    logic [LEN_W-1:0]   eff_len;
    logic [COUNT_W-1:0] free_space;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               pop;
    logic               tx_ready;

    assign eff_len    = (msgLen > LEN_W'(MSG_BYTES)) ? LEN_W'(MSG_BYTES) : msgLen;
    // Uses the registered count, so a pop on the same edge is not credited.
    assign free_space = COUNT_W'(FIFO_DEPTH) - fifoCount;

    assign wr_en   = (ld_state == LD_LOAD);
    assign wr_data = msg_q[MSG_W-1 -: 8];
    assign pop     = tx_ready && (fifoCount != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state <= LD_IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            msg_q    <= '0;
            rem_q    <= '0;
        end else begin
            overflow <= 1'b0;
            case (ld_state)
                LD_IDLE: begin
                    if (msgWrite && (eff_len != '0)) begin
                        if (32'(eff_len) > 32'(free_space)) begin
                            overflow <= 1'b1;
                        end else begin
                            msg_q    <= msgData;
                            rem_q    <= eff_len;
                            busy     <= 1'b1;
                            ld_state <= LD_LOAD;
                        end
                    end
                end
                LD_LOAD: begin
                    msg_q <= {msg_q[MSG_W-9:0], 8'h00};
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        busy     <= 1'b0;
                        ld_state <= LD_IDLE;
                    end
                end
                default: ld_state <= LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                fifoCount <= fifoCount + 1'b1;
            end else if (!wr_en && pop) begin
                fifoCount <= fifoCount - 1'b1;
            end
        end
    end

    // Mirrors the transmitter: set on every accepted byte, cleared when it goes idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            txActive <= 1'b0;
        end else if (pop) begin
            txActive <= 1'b1;
        end else if (tx_ready) begin
            txActive <= 1'b0;
        end
    end

    uart_byte_tx #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_byte_tx (
        .clk    (clk),
        .reset  (reset),
        .data   (mem[rd_ptr]),
        .start  (pop),
        .uart_tx(uart_tx),
        .ready  (tx_ready)
    );

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench for uart_msg_sender with a background 8N1 line decoder.
module tb_uart_msg_sender;

    localparam int D = 8;
    localparam int FRAME = 10 * D;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] msgData;
    logic [3:0]  msgLen;
    logic        msgWrite;
    logic        busy;
    logic        overflow;
    logic [4:0]  fifoCount;
    logic        txActive;
    logic        uart_tx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int low_cycles = 0;
    int framing_errors = 0;
    logic [7:0] rx_q[$];
    int start_q[$];
    logic [7:0] exp_q[$];

    uart_msg_sender #(
        .DELAY_FRAMES(D),
        .MSG_BYTES   (12),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .msgData  (msgData),
        .msgLen   (msgLen),
        .msgWrite (msgWrite),
        .busy     (busy),
        .overflow (overflow),
        .fifoCount(fifoCount),
        .txActive (txActive),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (uart_tx === 1'b0) low_cycles <= low_cycles + 1;

    // Line decoder: samples every bit at its midpoint.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (D / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (D) @(negedge clk);
                if (uart_tx !== 1'b1) framing_errors++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic strobe(input logic [95:0] d, input logic [3:0] len);
        msgData  = d;
        msgLen   = len;
        msgWrite = 1'b1;
        @(negedge clk);
        msgWrite = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((txActive !== 1'b0 || busy !== 1'b0 || fifoCount !== 5'd0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle", {30'd0, txActive, busy}, 32'd0);
    endtask

    initial begin
        logic [95:0] d;
        int lens[4];
        int k;
        int low_snap;
        lens = '{12, 12, 12, 4};
        reset = 1'b1;
        msgData = '0;
        msgLen = '0;
        msgWrite = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fifo_count", 32'(fifoCount), 32'd0);
        check("rst_tx_active", 32'(txActive), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // "Hi": busy for 2 cycles, line low at t+2, frames back to back.
        strobe({"Hi", 80'h0}, 4'd2);
        check("hi_busy_t1", 32'(busy), 32'd1);
        check("hi_tx_t1", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check("hi_busy_t2", 32'(busy), 32'd1);
        check("hi_tx_t2", 32'(uart_tx), 32'd1);
        check("hi_count_t2", 32'(fifoCount), 32'd1);
        @(negedge clk);
        check("hi_busy_t3", 32'(busy), 32'd0);
        check("hi_tx_low_t3", 32'(uart_tx), 32'd0);
        check("hi_active_t3", 32'(txActive), 32'd1);
        check("hi_count_t3", 32'(fifoCount), 32'd1);
        wait_rx(2, 3 * FRAME);
        if (rx_q.size() >= 2) begin
            check("hi_byte0", 32'(rx_q[0]), 32'h48);
            check("hi_byte1", 32'(rx_q[1]), 32'h69);
            check("hi_spacing", 32'(start_q[1] - start_q[0]), 32'(FRAME));
        end
        wait_idle(2 * FRAME);

        // Zero-length strobe does nothing.
        strobe({"Zz", 80'h0}, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("zero_count", 32'(fifoCount), 32'd0);
            check("zero_tx", 32'(uart_tx), 32'd1);
            check("zero_overflow", 32'(overflow), 32'd0);
            check("zero_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Overflow: 10 bytes queued behind a frame in flight, then an 8-byte request.
        rx_q.delete();
        start_q.delete();
        strobe({"ABCDEFGHIJK", 8'h00}, 4'd11);
        repeat (11) @(negedge clk);
        check("ovf_fill_count", 32'(fifoCount), 32'd10);
        check("ovf_fill_busy", 32'(busy), 32'd0);
        strobe({"xxxxxxxx", 32'h0}, 4'd8);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_count_t1", 32'(fifoCount), 32'd10);
        @(negedge clk);
        check("ovf_pulse_end", 32'(overflow), 32'd0);
        check("ovf_count_t2", 32'(fifoCount), 32'd10);
        wait_rx(11, 12 * FRAME);
        for (int i = 0; i < 11 && i < rx_q.size(); i++) begin
            check("ovf_byte", 32'(rx_q[i]), 32'h41 + 32'(i));
        end
        wait_idle(2 * FRAME);
        repeat (2 * FRAME) @(negedge clk);
        check("ovf_only_orig", 32'(rx_q.size()), 32'd11);

        // 40 bytes in four messages, crossing the pointer wrap.
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
        for (int m = 0; m < 4; m++) begin
            d = '0;
            for (int j = 0; j < lens[m]; j++) begin
                d[95 - 8 * j -: 8] = 8'(8'h10 + m * 8'h20 + j);
                exp_q.push_back(8'(8'h10 + m * 8'h20 + j));
            end
            k = 0;
            while ((busy !== 1'b0 || 32'(fifoCount) > 32'(16 - lens[m])) && k < 20 * FRAME) begin
                @(negedge clk);
                k++;
            end
            check("wrap_space", 32'(k < 20 * FRAME), 32'd1);
            strobe(d, 4'(lens[m]));
        end
        wait_rx(40, 45 * FRAME);
        for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
            check("wrap_byte", 32'(rx_q[i]), 32'(exp_q[i]));
        end
        wait_idle(2 * FRAME);

        // Over-long length is clamped to 12 bytes.
        rx_q.delete();
        start_q.delete();
        strobe(96'h0102030405060708090A0B0C, 4'd15);
        wait_rx(12, 14 * FRAME);
        wait_idle(2 * FRAME);
        repeat (2 * FRAME) @(negedge clk);
        check("clamp_count", 32'(rx_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
            check("clamp_byte", 32'(rx_q[i]), 32'(i + 1));
        end
        check("framing", 32'(framing_errors), 32'd0);

        // Reset in the middle of the 2nd frame's data bits.
        rx_q.delete();
        start_q.delete();
        strobe({8'h11, 8'h22, 8'h33, 72'h0}, 4'd3);
        k = 0;
        while (start_q.size() < 2 && k < 3 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("rst_second_start", 32'(start_q.size()), 32'd2);
        repeat (3 * D) @(negedge clk);
        check("rst_pre_active", 32'(txActive), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_count", 32'(fifoCount), 32'd0);
        check("midrst_active", 32'(txActive), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        low_snap = low_cycles;
        repeat (4 * FRAME) @(negedge clk);
        check("midrst_no_activity", 32'(low_cycles - low_snap), 32'd0);
        check("midrst_count_late", 32'(fifoCount), 32'd0);
        check("midrst_active_late", 32'(txActive), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
